// File: rtl/muldiv_if.sv
// Bundle between the datapath and the multiply/divide unit: operation requests,
// HI/LO moves, the HI/LO registers and the stall/status outputs.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             rd_hilo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;
  logic             dbz;
  logic [1:0]       dbg_state;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata, rd_hilo,
    input  hi, lo, busy, done, stall, dbz, dbg_state
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata, rd_hilo,
    output hi, lo, busy, done, stall, dbz, dbg_state
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32 shift-add or restoring shift-subtract
// steps on operand magnitudes, then one sign fix-up cycle that writes HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic             div_q;
  logic             neg_lo;   // product sign (mul) or quotient sign (div)
  logic             neg_hi;   // remainder sign, follows the dividend
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Odd op codes (MULT, DIV) are the signed variants.
  assign sa    = bus.op[0] & bus.a[WIDTH-1];
  assign sb    = bus.op[0] & bus.b[WIDTH-1];
  assign mag_a = sa ? -bus.a : bus.a;
  assign mag_b = sb ? -bus.b : bus.b;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, m_q};

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_lo ? -prod : prod;
  assign q_fix    = neg_lo ? -acc_lo : acc_lo;
  assign r_fix    = neg_hi ? -acc_hi : acc_hi;

  // Handshake: start is a request taken only when busy=0 (IDLE); the unit
  // holds busy=1 until the fix-up edge and then pulses done for one cycle.
  // While busy, any start/move/HI-LO read from the datapath raises stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      div_q  <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      m_q    <= '0;
      a_raw  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
            cnt    <= '0;
            dbz_q  <= 1'b0;
            div_q  <= bus.op[1];
            neg_lo <= sa ^ sb;
            neg_hi <= sa;
            acc_hi <= '0;
            acc_lo <= mag_a;
            m_q    <= mag_b;
            a_raw  <= bus.a;
          end else begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end
        end
        RUN: begin
          if (div_q) begin
            if (!div_diff[WIDTH]) begin
              acc_hi <= div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_sh[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          if (!div_q) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (m_q == '0) begin
            hi_q  <= a_raw;
            lo_q  <= '1;
            dbz_q <= 1'b1;
          end else begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          cnt    <= '0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbz       = dbz_q;
  assign bus.dbg_state = state;
  assign bus.stall     = busy_q & (bus.start | bus.mthi | bus.mtlo | bus.rd_hilo);
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random operations, with
// expected {dbz,HI,LO} pushed at start and popped when done pulses.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [2*W:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy, q, r;
    logic [2*W-1:0] p;
    logic [W-1:0] uq, ur;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    case (o)
      2'b00: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return {1'b0, p};
      end
      2'b01: begin
        p = sx * sy;
        return {1'b0, p};
      end
      default: begin
        if (y == '0) return {1'b1, x, {W{1'b1}}};
        if (o == 2'b10) begin
          uq = x / y;
          ur = x % y;
          return {1'b0, ur, uq};
        end
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[W-1:0], q[W-1:0]};
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0; bus.rd_hilo = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit mv_start, input bit mv_run,
                        input bit rd_run, input bit restart);
    logic [2*W:0] e;
    logic [W-1:0] hi_before, lo_before;
    int k, busy_cnt, hold_bad, stall_bad;
    bit any_req;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    bus.mthi = mv_start; bus.mtlo = mv_start; bus.wdata = $urandom;
    exp_q.push_back(model(o, x, y));
    @(posedge clk); #1;
    idle_inputs();
    n_cmp++;
    if (bus.dbz !== 1'b0) begin
      n_bad++; $display("FAIL %s dbz_at_e0: got %b want 0", name, bus.dbz);
    end
    hi_before = bus.hi; lo_before = bus.lo;
    k = 0; busy_cnt = 0; hold_bad = 0; stall_bad = 0;
    while (bus.done !== 1'b1 && k < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.hi !== hi_before || bus.lo !== lo_before) hold_bad++;
      bus.rd_hilo = rd_run && k >= 4;
      bus.start = restart && k == 9;
      if (bus.start) begin bus.op = ~o; bus.a = $urandom; bus.b = $urandom; end
      bus.mthi = mv_run && k == 2;
      bus.mtlo = mv_run && k == 2;
      bus.wdata = $urandom;
      #1;
      any_req = bus.start | bus.mthi | bus.mtlo | bus.rd_hilo;
      if (bus.stall !== (any_req && k < 33)) stall_bad++;
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (k >= 100) begin
      n_bad++; $display("FAIL %s done_timeout: got no done after %0d cycles want done", name, k);
    end
    n_cmp++;
    if (busy_cnt != 33) begin
      n_bad++; $display("FAIL %s busy_cycles: got %0d want 33", name, busy_cnt);
    end
    n_cmp++;
    if (hold_bad != 0) begin
      n_bad++; $display("FAIL %s hilo_hold: got %0d changed cycles want 0", name, hold_bad);
    end
    // done cycle: rd_hilo may still be high but the unit is idle
    n_cmp++;
    if (bus.stall !== 1'b0) stall_bad++;
    if (stall_bad != 0) begin
      n_bad++; $display("FAIL %s stall: got %0d wrong cycles want 0", name, stall_bad);
    end
    idle_inputs();
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s scoreboard: got empty queue want entry", name);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.dbz, bus.hi, bus.lo} !== e) begin
        n_bad++;
        $display("FAIL %s result: got dbz=%b hi=%h lo=%h want dbz=%b hi=%h lo=%h",
                 name, bus.dbz, bus.hi, bus.lo, e[2*W], e[2*W-1:W], e[W-1:0]);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL %s done_pulse: got done=%b busy=%b want 0 0", name, bus.done, bus.busy);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done, bus.dbz, bus.stall} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got busy=%b done=%b dbz=%b stall=%b want 0000",
                        bus.busy, bus.done, bus.dbz, bus.stall);
    end
    n_cmp++;
    if (bus.hi !== '0 || bus.lo !== '0) begin
      n_bad++; $display("FAIL reset_hilo: got hi=%h lo=%h want 0 0", bus.hi, bus.lo);
    end
    n_cmp++;
    if (bus.dbg_state !== 2'd0) begin
      n_bad++; $display("FAIL reset_state: got %0d want 0", bus.dbg_state);
    end
  endtask

  task automatic test_directed;
    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0);
    run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd5, 0, 0, 0, 0);
    run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 0);
    run_op("divu_zero", 2'b10, 32'd10, 32'd0, 0, 0, 0, 0);
    run_op("multu_after_dbz", 2'b00, 32'd7, 32'd6, 0, 0, 0, 0);
    run_op("div_overflow", 2'b11, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0);
    run_op("div_zero_signed", 2'b11, 32'hFFFFFF00, 32'd0, 0, 0, 0, 0);
    run_op("div_rem_sign", 2'b11, 32'd7, 32'hFFFFFFFE, 0, 0, 0, 0);
  endtask

  task automatic test_stall_restart;
    run_op("rd_hilo_restart", 2'b01, 32'h12345678, 32'hFEDCBA98, 0, 0, 1, 1);
  endtask

  task automatic test_moves;
    @(posedge clk); #1;
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hA5A5_0F0F;
    @(posedge clk); #1;
    idle_inputs();
    n_cmp++;
    if (bus.hi !== 32'hA5A5_0F0F || bus.lo !== 32'hA5A5_0F0F) begin
      n_bad++; $display("FAIL move_both: got hi=%h lo=%h want a5a50f0f a5a50f0f", bus.hi, bus.lo);
    end
    bus.mthi = 1'b1; bus.wdata = 32'h0000_BEEF;
    @(posedge clk); #1;
    idle_inputs();
    n_cmp++;
    if (bus.hi !== 32'h0000_BEEF || bus.lo !== 32'hA5A5_0F0F) begin
      n_bad++; $display("FAIL move_hi: got hi=%h lo=%h want 0000beef a5a50f0f", bus.hi, bus.lo);
    end
    run_op("start_with_move", 2'b10, 32'd1000, 32'd7, 1, 0, 0, 0);
    run_op("move_while_busy", 2'b00, 32'd123456, 32'd654321, 0, 1, 0, 0);
  endtask

  task automatic test_random;
    logic [1:0] o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 5) == 0) y = '0;
      if ($urandom_range(0, 4) == 0) y = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 4) == 0) x = 32'h80000000;
      run_op("random", o, x, y, 0, 0, $urandom_range(0, 1) == 1, 0);
    end
  endtask

  task automatic test_reset_mid;
    bit done_seen;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd99; bus.b = 32'd0;
    @(posedge clk); #1;
    idle_inputs();
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    n_cmp++;
    if ({bus.busy, bus.done, bus.dbz} !== 3'b000 || bus.dbg_state !== 2'd0) begin
      n_bad++; $display("FAIL reset_mid_flags: got busy=%b done=%b dbz=%b state=%0d want 0 0 0 0",
                        bus.busy, bus.done, bus.dbz, bus.dbg_state);
    end
    n_cmp++;
    if (bus.hi !== '0 || bus.lo !== '0) begin
      n_bad++; $display("FAIL reset_mid_hilo: got hi=%h lo=%h want 0 0", bus.hi, bus.lo);
    end
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
    end
    n_cmp++;
    if (done_seen) begin
      n_bad++; $display("FAIL reset_mid_discard: got done/busy activity want none");
    end
    bus.mthi = 1'b1; bus.wdata = 32'h0000_1234;
    @(posedge clk); #1;
    idle_inputs();
    n_cmp++;
    if (bus.hi !== 32'h0000_1234 || bus.lo !== '0) begin
      n_bad++; $display("FAIL mthi_after_reset: got hi=%h lo=%h want 00001234 0", bus.hi, bus.lo);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_stall_restart();
    test_moves();
    test_random();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
